// File: rtl/md5_bist_pkg.sv
// Shared types and helpers for the md5 self-test driver.
//   state_e     : controller states
//   LANE_W_DEF  : default message LFSR lane width
//   LFSR_TAPS   : feedback taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   misr_step() : one MISR compaction step, rotate-left-by-one then XOR the digest
package md5_bist_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int                    LANE_W_DEF = 8;
   localparam logic [LANE_W_DEF-1:0] LFSR_TAPS  = 8'hB8;

   // Widest signature misr_step() can compact; callers zero-extend into this
   // width and cast the result back down to their own width.
   localparam int MISR_MAX_W = 512;
   localparam int MISR_IDX_W = $clog2(MISR_MAX_W);

   // Only bits [width-1:0] of the result are meaningful. Bit 'width' picks up
   // the old MSB from the shift and is dropped by the caller's cast.
   function automatic logic [MISR_MAX_W-1:0] misr_step(
      input logic [MISR_MAX_W-1:0] sig,
      input logic [MISR_MAX_W-1:0] dig,
      input int                    width
   );
      logic [MISR_IDX_W-1:0] msb;
      logic [MISR_MAX_W-1:0] rot;
      msb = MISR_IDX_W'(width - 1);
      rot = (sig << 1) | MISR_MAX_W'(sig[msb]);
      return rot ^ dig;
   endfunction

endpackage

// File: rtl/md5_lfsr_lane.sv
// Next-state logic for one message LFSR lane. Purely combinational.
//   lane_i : current lane value
//   lane_o : advanced lane value; an all-zero lane is forced to 1 so it can
//            never lock up
module md5_lfsr_lane
   import md5_bist_pkg::*;
#(
   parameter int LANE_W = LANE_W_DEF
) (
   input  logic [LANE_W-1:0] lane_i,
   output logic [LANE_W-1:0] lane_o
);

   logic fb;

   assign fb     = ^(lane_i & LANE_W'(LFSR_TAPS));
   assign lane_o = (lane_i == '0) ? LANE_W'(1) : {lane_i[LANE_W-2:0], fb};

endmodule

// File: rtl/md5_bist_ctrl.sv
// Self-test driver for the md5 core. Issues LFSR-generated messages one at a
// time, waits a bounded window for each digest and folds the digests into a
// MISR signature. Timeouts are counted in err_count_o.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   start_i, abort_i  : run control (start honoured in IDLE/DONE only)
//   msg_in_valid_o    : one-cycle issue pulse, msg_padded_o valid with it
//   msg_padded_o      : current test message
//   digest_valid_i/digest_i : md5 core result (only looked at in WAIT)
//   busy_o, done_o    : run status
//   signature_o       : MISR value
//   err_count_o       : timeouts this run, saturating at 255
//
// state | meaning
// IDLE  | after reset, nothing run yet
// ISSUE | message pulse on msg_in_valid_o (exactly one cycle)
// WAIT  | waiting for digest or timeout window to expire
// DONE  | run finished or aborted, results held
module md5_bist_ctrl
   import md5_bist_pkg::*;
#(
   parameter int               MSG_W   = 512,
   parameter int               LANE_W  = 8,
   parameter int               DIG_W   = 128,
   parameter int               NUM_VEC = 16,
   parameter int               PERIOD  = 31,
   parameter logic [MSG_W-1:0] SEED    = {64{8'h5A}}
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             abort_i,
   output logic             msg_in_valid_o,
   output logic [MSG_W-1:0] msg_padded_o,
   input  logic             digest_valid_i,
   input  logic [DIG_W-1:0] digest_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [DIG_W-1:0] signature_o,
   output logic [7:0]       err_count_o
);

   localparam int NUM_LANES = MSG_W / LANE_W;
   localparam int VC_W      = (NUM_VEC == 0) ? 1 : $clog2(NUM_VEC + 1);
   localparam int WC_W      = $clog2(PERIOD);

   state_e           state_q, state_d;
   logic [MSG_W-1:0] msg_q, msg_d, msg_adv;
   logic [DIG_W-1:0] sig_q, sig_d;
   logic [7:0]       err_q, err_d;
   logic [VC_W-1:0]  vec_q, vec_d;
   logic [WC_W-1:0]  wait_q, wait_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             timeout;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      md5_lfsr_lane #(.LANE_W(LANE_W)) u_lane (
         .lane_i (msg_q[g*LANE_W +: LANE_W]),
         .lane_o (msg_adv[g*LANE_W +: LANE_W])
      );
   end

   assign timeout = (wait_q == WC_W'(PERIOD - 1));

   always_comb begin
      state_d = state_q;
      msg_d   = msg_q;
      sig_d   = sig_q;
      err_d   = err_q;
      vec_d   = vec_q;
      wait_d  = wait_q;
      case (state_q)
         IDLE, DONE: begin
            // abort outranks start when both arrive in DONE
            if (start_i && !(abort_i && state_q == DONE)) begin
               state_d = ISSUE;
               msg_d   = SEED;
               sig_d   = '0;
               err_d   = '0;
               vec_d   = '0;
               wait_d  = '0;
            end
         end
         ISSUE: begin
            if (abort_i) begin
               state_d = DONE;
            end else begin
               wait_d  = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (abort_i) begin
               state_d = DONE;
            end else begin
               wait_d = wait_q + WC_W'(1);
               // a digest on the last window cycle wins over the timeout
               if (digest_valid_i || timeout) begin
                  if (digest_valid_i) begin
                     sig_d = DIG_W'(misr_step(MISR_MAX_W'(sig_q), MISR_MAX_W'(digest_i), DIG_W));
                  end else if (err_q != 8'hFF) begin
                     err_d = err_q + 8'd1;
                  end
                  vec_d   = vec_q + VC_W'(1);
                  msg_d   = msg_adv;
                  state_d = ((NUM_VEC != 0) && (vec_d == VC_W'(NUM_VEC))) ? DONE : ISSUE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // status outputs are decoded from the next state so they come out of flops
      valid_d = (state_d == ISSUE);
      busy_d  = (state_d == ISSUE) || (state_d == WAIT);
      done_d  = (state_d == DONE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         msg_q   <= SEED;
         sig_q   <= '0;
         err_q   <= '0;
         vec_q   <= '0;
         wait_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         msg_q   <= msg_d;
         sig_q   <= sig_d;
         err_q   <= err_d;
         vec_q   <= vec_d;
         wait_q  <= wait_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign msg_in_valid_o = valid_q;
   assign msg_padded_o   = msg_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign signature_o    = sig_q;
   assign err_count_o    = err_q;

endmodule

// File: tb/tb_md5_bist_ctrl.sv
// Bench for md5_bist_ctrl. Instance A: 16-bit messages, 8-bit digests,
// 3 vectors per run, 31-cycle window. Instance B: free-running with a 4-cycle
// window, seeded with an all-zero and an all-ones lane.
module tb_md5_bist_ctrl;

   localparam int          PER_A  = 31;
   localparam int          PER_B  = 4;
   localparam int          NV_A   = 3;
   localparam logic [15:0] SEED_A = 16'h8001;
   localparam logic [15:0] SEED_B = 16'hFF00;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        start_a = 1'b0, abort_a = 1'b0, dv_a = 1'b0;
   logic [7:0]  dig_a = 8'h00;
   logic        mv_a, busy_a, done_a;
   logic [15:0] msg_a;
   logic [7:0]  sig_a, err_a;

   logic        start_b = 1'b0, abort_b = 1'b0, dv_b = 1'b0;
   logic [7:0]  dig_b = 8'h00;
   logic        mv_b, busy_b, done_b;
   logic [15:0] msg_b;
   logic [7:0]  sig_b, err_b;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [15:0] qa[$];
   logic [15:0] qb[$];
   logic [15:0] m_a, m_b;
   logic [7:0]  sig_m;

   always #5 clk = ~clk;

   md5_bist_ctrl #(
      .MSG_W(16), .LANE_W(8), .DIG_W(8), .NUM_VEC(NV_A), .PERIOD(PER_A), .SEED(SEED_A)
   ) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .abort_i(abort_a),
      .msg_in_valid_o(mv_a), .msg_padded_o(msg_a),
      .digest_valid_i(dv_a), .digest_i(dig_a),
      .busy_o(busy_a), .done_o(done_a), .signature_o(sig_a), .err_count_o(err_a)
   );

   md5_bist_ctrl #(
      .MSG_W(16), .LANE_W(8), .DIG_W(8), .NUM_VEC(0), .PERIOD(PER_B), .SEED(SEED_B)
   ) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .abort_i(abort_b),
      .msg_in_valid_o(mv_b), .msg_padded_o(msg_b),
      .digest_valid_i(dv_b), .digest_i(dig_b),
      .busy_o(busy_b), .done_o(done_b), .signature_o(sig_b), .err_count_o(err_b)
   );

   function automatic logic [7:0] lane_nx(input logic [7:0] b);
      if (b == 8'h00) return 8'h01;
      return {b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]};
   endfunction

   function automatic logic [15:0] msg_nx(input logic [15:0] m);
      return {lane_nx(m[15:8]), lane_nx(m[7:0])};
   endfunction

   function automatic logic [7:0] misr(input logic [7:0] s, input logic [7:0] d);
      return {s[6:0], s[7]} ^ d;
   endfunction

   // leaves the caller on the negedge where the first pulse should show
   task automatic kick_a();
      qa.delete();
      m_a   = SEED_A;
      sig_m = 8'h00;
      qa.push_back(m_a);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
   endtask

   task automatic kick_b();
      qb.delete();
      m_b = SEED_B;
      qb.push_back(m_b);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
   endtask

   task automatic wait_pulse_b(input int max_cyc, output bit seen, output int cyc);
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
         if (mv_b === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({mv_a, busy_a, done_a} !== 3'b000) begin
         n_bad++; $display("FAIL rst_ctrl_a: got %b want 000", {mv_a, busy_a, done_a});
      end
      n_vec++;
      if (msg_a !== SEED_A) begin
         n_bad++; $display("FAIL rst_msg_a: got %h want %h", msg_a, SEED_A);
      end
      n_vec++;
      if (sig_a !== 8'h00 || err_a !== 8'h00) begin
         n_bad++; $display("FAIL rst_sig_err_a: got sig=%h err=%0d want 0/0", sig_a, err_a);
      end
      n_vec++;
      if (msg_b !== SEED_B || {mv_b, busy_b, done_b} !== 3'b000) begin
         n_bad++; $display("FAIL rst_b: got msg=%h ctrl=%b want %h/000", msg_b, {mv_b, busy_b, done_b}, SEED_B);
      end
      rst_n = 1'b1;
      @(negedge clk);
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({mv_a, busy_a, done_a} !== 3'b000) begin
         n_bad++; $display("FAIL abort_in_idle: got ctrl=%b want 000", {mv_a, busy_a, done_a});
      end
   endtask

   task automatic test_vectors();
      logic [15:0] exp;
      logic [7:0]  dg;
      kick_a();
      exp = (qa.size() != 0) ? qa.pop_front() : 'x;
      n_vec++;
      if (mv_a !== 1'b1 || msg_a !== exp) begin
         n_bad++; $display("FAIL vec_pulse0: got valid=%b msg=%h want 1/%h", mv_a, msg_a, exp);
      end
      n_vec++;
      if (busy_a !== 1'b1 || done_a !== 1'b0) begin
         n_bad++; $display("FAIL vec_busy: got busy=%b done=%b want 1/0", busy_a, done_a);
      end
      for (int i = 0; i < NV_A; i++) begin
         dg = 8'(i + 1);
         repeat (2) @(negedge clk);
         dv_a  = 1'b1;
         dig_a = dg;
         sig_m = misr(sig_m, dg);
         m_a   = msg_nx(m_a);
         if (i < NV_A - 1) qa.push_back(m_a);
         @(negedge clk);
         dv_a = 1'b0;
         if (i < NV_A - 1) begin
            exp = (qa.size() != 0) ? qa.pop_front() : 'x;
            n_vec++;
            if (mv_a !== 1'b1 || msg_a !== exp || sig_a !== sig_m) begin
               n_bad++;
               $display("FAIL vec_pulse%0d: got valid=%b msg=%h sig=%h want 1/%h/%h",
                        i + 1, mv_a, msg_a, sig_a, exp, sig_m);
            end
         end
      end
      n_vec++;
      if (done_a !== 1'b1 || busy_a !== 1'b0 || mv_a !== 1'b0) begin
         n_bad++; $display("FAIL vec_done: got done=%b busy=%b valid=%b want 1/0/0", done_a, busy_a, mv_a);
      end
      n_vec++;
      if (sig_a !== sig_m || err_a !== 8'h00) begin
         n_bad++; $display("FAIL vec_signature: got sig=%h err=%0d want %h/0", sig_a, err_a, sig_m);
      end
      n_vec++;
      if (msg_a !== m_a) begin
         n_bad++; $display("FAIL vec_final_msg: got %h want %h", msg_a, m_a);
      end
      dv_a  = 1'b1;
      dig_a = 8'hFF;
      @(negedge clk);
      dv_a = 1'b0;
      @(negedge clk);
      n_vec++;
      if (sig_a !== sig_m || done_a !== 1'b1) begin
         n_bad++; $display("FAIL vec_digest_in_done: got sig=%h done=%b want %h/1", sig_a, done_a, sig_m);
      end
   endtask

   task automatic test_timeout();
      logic [15:0] exp;
      int          first_err;
      int          pulse_at;
      kick_a();
      exp = (qa.size() != 0) ? qa.pop_front() : 'x;
      n_vec++;
      if (mv_a !== 1'b1 || msg_a !== exp) begin
         n_bad++; $display("FAIL to_pulse0: got valid=%b msg=%h want 1/%h", mv_a, msg_a, exp);
      end
      n_vec++;
      if (sig_a !== 8'h00 || err_a !== 8'h00 || done_a !== 1'b0) begin
         n_bad++; $display("FAIL to_cleared: got sig=%h err=%0d done=%b want 0/0/0", sig_a, err_a, done_a);
      end
      m_a = msg_nx(m_a);
      qa.push_back(m_a);
      first_err = 0;
      pulse_at  = 0;
      for (int c = 1; c <= PER_A + 1; c++) begin
         @(negedge clk);
         if (err_a === 8'd1 && first_err == 0) first_err = c;
         if (mv_a === 1'b1 && pulse_at == 0) pulse_at = c;
      end
      n_vec++;
      if (first_err != PER_A + 1) begin
         n_bad++; $display("FAIL to_err_cycle: got %0d want %0d", first_err, PER_A + 1);
      end
      n_vec++;
      if (pulse_at != PER_A + 1) begin
         n_bad++; $display("FAIL to_spacing: got %0d want %0d", pulse_at, PER_A + 1);
      end
      exp = (qa.size() != 0) ? qa.pop_front() : 'x;
      n_vec++;
      if (msg_a !== exp) begin
         n_bad++; $display("FAIL to_msg1: got %h want %h", msg_a, exp);
      end
      // digest arrives on the final cycle of the window
      repeat (PER_A) @(negedge clk);
      n_vec++;
      if (mv_a !== 1'b0 || busy_a !== 1'b1) begin
         n_bad++; $display("FAIL to_still_waiting: got valid=%b busy=%b want 0/1", mv_a, busy_a);
      end
      dv_a  = 1'b1;
      dig_a = 8'hA5;
      sig_m = misr(sig_m, 8'hA5);
      m_a   = msg_nx(m_a);
      qa.push_back(m_a);
      @(negedge clk);
      dv_a = 1'b0;
      exp = (qa.size() != 0) ? qa.pop_front() : 'x;
      n_vec++;
      if (mv_a !== 1'b1 || msg_a !== exp) begin
         n_bad++; $display("FAIL to_late_pulse: got valid=%b msg=%h want 1/%h", mv_a, msg_a, exp);
      end
      n_vec++;
      if (err_a !== 8'd1 || sig_a !== sig_m) begin
         n_bad++; $display("FAIL to_late_digest: got err=%0d sig=%h want 1/%h", err_a, sig_a, sig_m);
      end
      repeat (PER_A + 1) @(negedge clk);
      m_a = msg_nx(m_a);
      n_vec++;
      if (done_a !== 1'b1 || err_a !== 8'd2 || sig_a !== sig_m || msg_a !== m_a) begin
         n_bad++;
         $display("FAIL to_done: got done=%b err=%0d sig=%h msg=%h want 1/2/%h/%h",
                  done_a, err_a, sig_a, msg_a, sig_m, m_a);
      end
   endtask

   task automatic test_abort();
      logic [15:0] exp;
      int          pulses;
      kick_a();
      exp = (qa.size() != 0) ? qa.pop_front() : 'x;
      n_vec++;
      if (mv_a !== 1'b1 || msg_a !== exp) begin
         n_bad++; $display("FAIL ab_pulse: got valid=%b msg=%h want 1/%h", mv_a, msg_a, exp);
      end
      repeat (2) @(negedge clk);
      dv_a    = 1'b1;
      dig_a   = 8'h3C;
      abort_a = 1'b1;
      @(negedge clk);
      dv_a    = 1'b0;
      abort_a = 1'b0;
      n_vec++;
      if (done_a !== 1'b1 || busy_a !== 1'b0 || mv_a !== 1'b0) begin
         n_bad++; $display("FAIL ab_state: got done=%b busy=%b valid=%b want 1/0/0", done_a, busy_a, mv_a);
      end
      n_vec++;
      if (sig_a !== 8'h00 || msg_a !== SEED_A || err_a !== 8'h00) begin
         n_bad++; $display("FAIL ab_hold: got sig=%h msg=%h err=%0d want 00/%h/0", sig_a, msg_a, err_a, SEED_A);
      end
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         if (mv_a === 1'b1) pulses++;
      end
      n_vec++;
      if (pulses != 0 || done_a !== 1'b1) begin
         n_bad++; $display("FAIL ab_quiet: got pulses=%0d done=%b want 0/1", pulses, done_a);
      end
      start_a = 1'b1;
      abort_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      abort_a = 1'b0;
      @(negedge clk);
      n_vec++;
      if (done_a !== 1'b1 || busy_a !== 1'b0 || mv_a !== 1'b0) begin
         n_bad++; $display("FAIL ab_start_with_abort: got done=%b busy=%b valid=%b want 1/0/0", done_a, busy_a, mv_a);
      end
      kick_a();
      exp = (qa.size() != 0) ? qa.pop_front() : 'x;
      n_vec++;
      if (mv_a !== 1'b1 || msg_a !== exp || sig_a !== 8'h00 || done_a !== 1'b0) begin
         n_bad++;
         $display("FAIL ab_restart: got valid=%b msg=%h sig=%h done=%b want 1/%h/00/0", mv_a, msg_a, sig_a, done_a, exp);
      end
   endtask

   task automatic test_reset_midrun();
      logic [15:0] exp;
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      kick_a();
      exp = (qa.size() != 0) ? qa.pop_front() : 'x;
      n_vec++;
      if (mv_a !== 1'b1 || msg_a !== exp) begin
         n_bad++; $display("FAIL rm_pulse0: got valid=%b msg=%h want 1/%h", mv_a, msg_a, exp);
      end
      repeat (2) @(negedge clk);
      dv_a  = 1'b1;
      dig_a = 8'h77;
      sig_m = misr(sig_m, 8'h77);
      m_a   = msg_nx(m_a);
      qa.push_back(m_a);
      @(negedge clk);
      dv_a = 1'b0;
      exp = (qa.size() != 0) ? qa.pop_front() : 'x;
      n_vec++;
      if (mv_a !== 1'b1 || msg_a !== exp || sig_a !== sig_m) begin
         n_bad++; $display("FAIL rm_pulse1: got valid=%b msg=%h sig=%h want 1/%h/%h", mv_a, msg_a, sig_a, exp, sig_m);
      end
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({mv_a, busy_a, done_a} !== 3'b000) begin
         n_bad++; $display("FAIL rm_async_ctrl: got %b want 000", {mv_a, busy_a, done_a});
      end
      n_vec++;
      if (msg_a !== SEED_A || sig_a !== 8'h00 || err_a !== 8'h00) begin
         n_bad++; $display("FAIL rm_async_data: got msg=%h sig=%h err=%0d want %h/00/0", msg_a, sig_a, err_a, SEED_A);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
         n_bad++; $display("FAIL rm_no_done: got done=%b busy=%b want 0/0", done_a, busy_a);
      end
      kick_a();
      exp = (qa.size() != 0) ? qa.pop_front() : 'x;
      n_vec++;
      if (mv_a !== 1'b1 || msg_a !== exp) begin
         n_bad++; $display("FAIL rm_restart: got valid=%b msg=%h want 1/%h", mv_a, msg_a, exp);
      end
   endtask

   task automatic test_free_run();
      logic [15:0] exp;
      logic [7:0]  e_b;
      bit          seen;
      int          cyc;
      kick_b();
      exp = (qb.size() != 0) ? qb.pop_front() : 'x;
      n_vec++;
      if (mv_b !== 1'b1 || msg_b !== exp) begin
         n_bad++; $display("FAIL fr_pulse0: got valid=%b msg=%h want 1/%h", mv_b, msg_b, exp);
      end
      e_b = 8'h00;
      for (int v = 1; v <= 260; v++) begin
         m_b = msg_nx(m_b);
         qb.push_back(m_b);
         if (e_b != 8'hFF) e_b = e_b + 8'd1;
         wait_pulse_b(PER_B + 3, seen, cyc);
         exp = (qb.size() != 0) ? qb.pop_front() : 'x;
         n_vec++;
         if (!seen || cyc != PER_B + 1 || msg_b !== exp || err_b !== e_b) begin
            n_bad++;
            $display("FAIL fr_vec%0d: got seen=%b gap=%0d msg=%h err=%0d want 1/%0d/%h/%0d",
                     v, seen, cyc, msg_b, err_b, PER_B + 1, exp, e_b);
         end
         if (v == 1) begin
            n_vec++;
            if (msg_b !== 16'hFE01) begin
               n_bad++; $display("FAIL fr_lane_edges: got %h want fe01", msg_b);
            end
         end
      end
      n_vec++;
      if (err_b !== 8'hFF || done_b !== 1'b0 || busy_b !== 1'b1) begin
         n_bad++; $display("FAIL fr_saturate: got err=%0d done=%b busy=%b want 255/0/1", err_b, done_b, busy_b);
      end
      repeat (2) @(negedge clk);
      abort_b = 1'b1;
      @(negedge clk);
      abort_b = 1'b0;
      n_vec++;
      if (done_b !== 1'b1 || busy_b !== 1'b0 || msg_b !== m_b || err_b !== 8'hFF) begin
         n_bad++;
         $display("FAIL fr_abort: got done=%b busy=%b msg=%h err=%0d want 1/0/%h/255", done_b, busy_b, msg_b, err_b, m_b);
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_timeout();
      test_abort();
      test_reset_midrun();
      test_free_run();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
